// File: rtl/alu_top.sv
// MIPS-style execute-stage ALU: opcode/funct decode, 32-bit operation and
// registered result plus zero flag, one-cycle latency.
module alu_top #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI,
    OP_NONE
  } alu_op_t;

  alu_op_t          alu_op;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] next_result;

  assign shamt = A[4:0];

  // func_field only matters for R-type; I-type ops decode from opcode alone
  always_comb begin
    alu_op = OP_NONE;
    if (opcode == 6'h00) begin
      unique case (func_field)
        6'h20, 6'h21: alu_op = OP_ADD;
        6'h22, 6'h23: alu_op = OP_SUB;
        6'h24:        alu_op = OP_AND;
        6'h25:        alu_op = OP_OR;
        6'h26:        alu_op = OP_XOR;
        6'h27:        alu_op = OP_NOR;
        6'h2A:        alu_op = OP_SLT;
        6'h2B:        alu_op = OP_SLTU;
        6'h00:        alu_op = OP_SLL;
        6'h02:        alu_op = OP_SRL;
        6'h03:        alu_op = OP_SRA;
        default:      alu_op = OP_NONE;
      endcase
    end else begin
      unique case (opcode)
        6'h23, 6'h2B, 6'h08, 6'h09: alu_op = OP_ADD;
        6'h04, 6'h05:               alu_op = OP_SUB;
        6'h0A:                      alu_op = OP_SLT;
        6'h0B:                      alu_op = OP_SLTU;
        6'h0C:                      alu_op = OP_AND;
        6'h0D:                      alu_op = OP_OR;
        6'h0E:                      alu_op = OP_XOR;
        6'h0F:                      alu_op = OP_LUI;
        default:                    alu_op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    next_result = '0;
    unique case (alu_op)
      OP_ADD:  next_result = A + B;
      OP_SUB:  next_result = A - B;
      OP_AND:  next_result = A & B;
      OP_OR:   next_result = A | B;
      OP_XOR:  next_result = A ^ B;
      OP_NOR:  next_result = ~(A | B);
      OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  next_result = B << shamt;
      OP_SRL:  next_result = B >> shamt;
      OP_SRA:  next_result = $unsigned($signed(B) >>> shamt);
      OP_LUI:  next_result = B << 16;
      default: next_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
    end else begin
      result <= next_result;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: driver pushes hand-computed expectations,
// monitor pops one per clock edge and compares result/zero.
module tb_alu_top;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  func_field;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        zero;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [32:0] exp_q[$];
  string       name_q[$];

  alu_top #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func_field (func_field),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input string nm, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_zero);
    @(negedge clk);
    rst        = r;
    opcode     = op;
    func_field = fn;
    A          = a;
    B          = b;
    exp_q.push_back({exp_res, exp_zero});
    name_q.push_back(nm);
  endtask

  // Monitor: each active edge consumes the expectation issued before it
  initial begin
    logic [32:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (result === e[32:1] && zero === e[0]) n_pass++;
        else $display("FAIL %s: got result=%h zero=%b, want result=%h zero=%b",
                      nm, result, zero, e[32:1], e[0]);
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    opcode     = '0;
    func_field = '0;
    A          = '0;
    B          = '0;

    issue("rst0", 1, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h0, 1'b0);
    issue("rst1", 1, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h0, 1'b0);
    issue("add_after_rst", 0, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h3333, 1'b0);
    issue("and", 0, 6'h00, 6'h24, 32'h2222, 32'h1111, 32'h0, 1'b1);
    issue("addu", 0, 6'h00, 6'h21, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001, 1'b0);
    issue("sub", 0, 6'h00, 6'h22, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    issue("subu", 0, 6'h00, 6'h23, 32'h10, 32'h3, 32'hD, 1'b0);
    issue("or", 0, 6'h00, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);
    issue("xor", 0, 6'h00, 6'h26, 32'hFF00_FF00, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0);
    issue("nor", 0, 6'h00, 6'h27, 32'hFF00_FF00, 32'h00FF_0000, 32'h0000_00FF, 1'b0);
    issue("slt_pos", 0, 6'h00, 6'h2A, 32'h1111, 32'h2222, 32'h1, 1'b0);
    issue("slt_neg", 0, 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    issue("sltu", 0, 6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    issue("add_wrap", 0, 6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    issue("sra", 0, 6'h00, 6'h03, 32'h4, 32'h8000_0000, 32'hF800_0000, 1'b0);
    issue("srl", 0, 6'h00, 6'h02, 32'h4, 32'h8000_0000, 32'h0800_0000, 1'b0);
    issue("sll_amt5", 0, 6'h00, 6'h00, 32'h25, 32'h1, 32'h20, 1'b0);
    issue("lw", 0, 6'h23, 6'h00, 32'h2222, 32'h1111, 32'h3333, 1'b0);
    issue("lw_func_ign", 0, 6'h23, 6'h24, 32'h2222, 32'h1111, 32'h3333, 1'b0);
    issue("sw", 0, 6'h2B, 6'h00, 32'h100, 32'hFFFF_FFFC, 32'hFC, 1'b0);
    issue("addi", 0, 6'h08, 6'h00, 32'h5, 32'h7, 32'hC, 1'b0);
    issue("addiu", 0, 6'h09, 6'h00, 32'h5, 32'hFFFF_FFFB, 32'h0, 1'b1);
    issue("beq_eq", 0, 6'h04, 6'h00, 32'h5555, 32'h5555, 32'h0, 1'b1);
    issue("beq_ne", 0, 6'h04, 6'h00, 32'h5555, 32'h5554, 32'h1, 1'b0);
    issue("bne", 0, 6'h05, 6'h00, 32'h5554, 32'h5555, 32'hFFFF_FFFF, 1'b0);
    issue("slti", 0, 6'h0A, 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    issue("sltiu", 0, 6'h0B, 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    issue("andi", 0, 6'h0C, 6'h00, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0);
    issue("ori", 0, 6'h0D, 6'h00, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);
    issue("xori", 0, 6'h0E, 6'h00, 32'h0000_FFFF, 32'h0000_F0F0, 32'h0000_0F0F, 1'b0);
    issue("lui", 0, 6'h0F, 6'h00, 32'hDEAD_BEEF, 32'h1234, 32'h1234_0000, 1'b0);
    issue("bad_opcode", 0, 6'h3F, 6'h20, 32'h2222, 32'h1111, 32'h0, 1'b1);
    issue("bad_func", 0, 6'h00, 6'h3F, 32'h2222, 32'h1111, 32'h0, 1'b1);
    issue("pre_midrst", 0, 6'h00, 6'h20, 32'h1, 32'h2, 32'h3, 1'b0);
    issue("midrst", 1, 6'h00, 6'h20, 32'h4, 32'h5, 32'h0, 1'b0);
    issue("post_midrst", 0, 6'h00, 6'h25, 32'h4, 32'h5, 32'h5, 1'b0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- MIPS-style 32-bit integer ALU with built-in ALU-control decode, sitting in the execute stage of the datapath.
- Decodes the 6-bit primary opcode and, for R-type (opcode 0x00), the 6-bit function field into an operation.
- Applies that operation to operands A and B and registers the 32-bit result plus a zero flag.
- Operand B arrives already selected and extended upstream (register value or sign/zero-extended immediate); this block does no immediate extension.

Parameters:
- WIDTH, 32, datapath width of A, B and result (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instruction primary opcode.
- func_field  input  6  instruction function field; used only when opcode = 0x00.
- A  input  32  operand A (rs value); A[4:0] is the shift amount for shift operations.
- B  input  32  operand B (rt value or pre-extended immediate).
- result  output  32  registered ALU result.
- zero  output  1  registered flag, 1 when result = 0.

Behaviour:
- Timing: one-cycle latency. Inputs are sampled at each rising clk; result and zero update at that same edge. No handshake; a new operation can be issued every cycle. Decode and arithmetic are combinational ahead of the output registers.
- Reset: rst is sampled only at the rising clk. When rst = 1 at an edge, result <= 0 and zero <= 0, overriding any operation. Reset asserted mid-stream discards the operation sampled at that edge.
- Outside reset: zero <= (next result == 0) for every opcode, including unsupported ones.
- R-type decode (opcode 0x00), by func_field:
  - 0x20 add, 0x21 addu: A+B.
  - 0x22 sub, 0x23 subu: A-B.
  - 0x24 and: A&B.
  - 0x25 or: A|B.
  - 0x26 xor: A^B.
  - 0x27 nor: ~(A|B).
  - 0x2A slt: signed A<B gives 1, else 0.
  - 0x2B sltu: unsigned A<B gives 1, else 0.
  - 0x00 sll: B<<A[4:0].
  - 0x02 srl: B>>A[4:0], logical.
  - 0x03 sra: B>>>A[4:0], arithmetic.
- I-type decode, by opcode:
  - 0x23 lw, 0x2B sw, 0x08 addi, 0x09 addiu: A+B.
  - 0x04 beq, 0x05 bne: A-B; the branch decision uses zero externally.
  - 0x0A slti: signed compare. 0x0B sltiu: unsigned compare.
  - 0x0C andi: A&B. 0x0D ori: A|B. 0x0E xori: A^B.
  - 0x0F lui: B<<16.
- Arithmetic:
  - Add and subtract wrap modulo 2^32. No overflow trap or flag, for signed or unsigned forms.
  - Signed compare uses two's-complement interpretation of the full 32 bits.
  - slt/sltu results are zero-extended to 32 bits.
  - Shift amounts use only A[4:0]; A[31:5] is ignored.
- Unsupported cases: any other opcode, or opcode 0x00 with an unlisted func_field, gives result = 0 and zero = 1.
- func_field is ignored for non-zero opcodes. Example: opcode 0x23 with func 0x00 performs add.

Test Plan:
- Reset: assert rst for 2 edges with A=0x2222, B=0x1111, opcode 0x00, func 0x20 -> result=0, zero=0. First edge after release -> result=0x00003333, zero=0.
- R-type add/and: A=0x2222, B=0x1111. Func 0x20 -> 0x3333, zero=0. Func 0x24 -> 0x0000, zero=1. Each result appears one edge after the inputs.
- I-type lw/beq: opcode 0x23, func 0x00, A=0x2222, B=0x1111 -> 0x3333. Opcode 0x04, A=B=0x5555 -> result 0, zero=1. Opcode 0x04, A=0x5555, B=0x5554 -> result 1, zero=0.
- slt/sltu: func 0x2A, A=0x1111, B=0x2222 -> 1. Func 0x2A, A=0xFFFFFFFF, B=0x1 -> 1 (signed). Func 0x2B with the same operands -> 0, zero=1.
- Wrap and shifts:
  - add 0xFFFFFFFF+1 -> 0, zero=1.
  - sub 0-1 -> 0xFFFFFFFF.
  - sra, B=0x80000000, A=4 -> 0xF8000000.
  - srl with the same operands -> 0x08000000.
  - sll, B=1, A=0x25 (uses 5) -> 0x20.
  - lui, B=0x1234 -> 0x12340000.
- Unsupported: opcode 0x3F -> result 0, zero=1. Opcode 0x00 with func 0x3F -> result 0, zero=1. Back-to-back issue of different operations every cycle -> each result appears exactly one edge later.
